// File: rtl/register_file_mp_if.sv
// Register-file port bundle: two write ports, two read ports and the busy-scoreboard hooks.
interface register_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic              wr_en0;
  logic [ADDR_W-1:0] wr_addr0;
  logic [DATA_W-1:0] wr_data0;
  logic              wr_en1;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data1;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy_set;
  logic [ADDR_W-1:0] busy_addr;
  logic              busy_a;
  logic              busy_b;

  modport master (
    output wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1,
    output rd_addr_a, rd_addr_b, busy_set, busy_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b
  );

  modport slave (
    input  wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1,
    input  rd_addr_a, rd_addr_b, busy_set, busy_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b
  );
endinterface

// File: rtl/register_file_mp.sv
// Two-write / two-read register file with optional forwarding, hardwired zero
// register and a per-register pending-write scoreboard.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic               clk,
  input logic               rst,
  register_file_mp_if.slave bus
);

  localparam logic [ADDR_W:0] LP_NUM = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_busy [NUM_REGS];

  logic              w_we0, w_we1, w_set, w_byp;
  logic              w_hit0_a, w_hit1_a, w_hit0_b, w_hit1_b;
  logic [DATA_W-1:0] w_rd_a, w_rd_b;
  logic              w_bq_a, w_bq_b;

  // An address is writable/markable only if in range and not the hardwired zero.
  function automatic logic f_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < LP_NUM) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_we0 = bus.wr_en0   && f_live(bus.wr_addr0);
  assign w_we1 = bus.wr_en1   && f_live(bus.wr_addr1);
  assign w_set = bus.busy_set && f_live(bus.busy_addr);
  assign w_byp = (BYPASS != 0) && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
        r_busy[i] <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        // Later assignments win: port 1 over port 0, busy set over clear.
        if (w_we0 && bus.wr_addr0 == ADDR_W'(i)) begin
          r_regs[i] <= bus.wr_data0;
          r_busy[i] <= 1'b0;
        end
        if (w_we1 && bus.wr_addr1 == ADDR_W'(i)) begin
          r_regs[i] <= bus.wr_data1;
          r_busy[i] <= 1'b0;
        end
        if (w_set && bus.busy_addr == ADDR_W'(i)) begin
          r_busy[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    w_bq_a = 1'b0;
    w_bq_b = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr_a == ADDR_W'(i)) begin
        w_rd_a = r_regs[i];
        w_bq_a = r_busy[i];
      end
      if (bus.rd_addr_b == ADDR_W'(i)) begin
        w_rd_b = r_regs[i];
        w_bq_b = r_busy[i];
      end
    end
  end

  assign w_hit0_a = w_byp && w_we0 && (bus.wr_addr0 == bus.rd_addr_a);
  assign w_hit1_a = w_byp && w_we1 && (bus.wr_addr1 == bus.rd_addr_a);
  assign w_hit0_b = w_byp && w_we0 && (bus.wr_addr0 == bus.rd_addr_b);
  assign w_hit1_b = w_byp && w_we1 && (bus.wr_addr1 == bus.rd_addr_b);

  assign bus.rd_data_a = w_hit1_a ? bus.wr_data1 : (w_hit0_a ? bus.wr_data0 : w_rd_a);
  assign bus.rd_data_b = w_hit1_b ? bus.wr_data1 : (w_hit0_b ? bus.wr_data0 : w_rd_b);
  assign bus.busy_a    = w_bq_a & ~(w_hit0_a | w_hit1_a);
  assign bus.busy_b    = w_bq_b & ~(w_hit0_b | w_hit1_b);

endmodule

// File: tb/tb_register_file_mp.sv
// Bench: one forwarding and one non-forwarding instance driven in lockstep and
// compared each cycle against an array-based model, plus literal directed checks.
module tb_register_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en0 = 0, wr_en1 = 0, busy_set = 0;
  logic [AW-1:0] wr_addr0 = 0, wr_addr1 = 0, rd_addr_a = 0, rd_addr_b = 0, busy_addr = 0;
  logic [DW-1:0] wr_data0 = 0, wr_data1 = 0;

  register_file_mp_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();
  register_file_mp_if #(.DATA_W(DW), .ADDR_W(AW)) ifn ();

  assign ifb.wr_en0 = wr_en0;     assign ifn.wr_en0 = wr_en0;
  assign ifb.wr_addr0 = wr_addr0; assign ifn.wr_addr0 = wr_addr0;
  assign ifb.wr_data0 = wr_data0; assign ifn.wr_data0 = wr_data0;
  assign ifb.wr_en1 = wr_en1;     assign ifn.wr_en1 = wr_en1;
  assign ifb.wr_addr1 = wr_addr1; assign ifn.wr_addr1 = wr_addr1;
  assign ifb.wr_data1 = wr_data1; assign ifn.wr_data1 = wr_data1;
  assign ifb.rd_addr_a = rd_addr_a; assign ifn.rd_addr_a = rd_addr_a;
  assign ifb.rd_addr_b = rd_addr_b; assign ifn.rd_addr_b = rd_addr_b;
  assign ifb.busy_set = busy_set; assign ifn.busy_set = busy_set;
  assign ifb.busy_addr = busy_addr; assign ifn.busy_addr = busy_addr;

  register_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1))
    dut_byp (.clk(clk), .rst(rst), .bus(ifb));
  register_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0))
    dut_nob (.clk(clk), .rst(rst), .bus(ifn));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: architectural contents and pending bits as plain arrays.
  logic [DW-1:0] m_mem [NR];
  bit            m_bsy [NR];

  function automatic bit in_file(input int a);
    return a > 0 && a < NR;   // register 0 is the hardwired zero
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int a, input bit byp);
    logic [DW-1:0] d;
    if (!rst || !in_file(a)) return '0;
    d = m_mem[a];
    if (byp && wr_en0 && int'(wr_addr0) == a) d = wr_data0;
    if (byp && wr_en1 && int'(wr_addr1) == a) d = wr_data1;
    return d;
  endfunction

  function automatic logic exp_bz(input int a, input bit byp);
    if (!rst || !in_file(a)) return 1'b0;
    if (byp && ((wr_en0 && int'(wr_addr0) == a) || (wr_en1 && int'(wr_addr1) == a)))
      return 1'b0;
    return m_bsy[a];
  endfunction

  initial for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_bsy[i] = 0; end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_bsy[i] = 0; end
    end else begin
      if (wr_en0 && in_file(int'(wr_addr0))) begin m_mem[wr_addr0] = wr_data0; m_bsy[wr_addr0] = 0; end
      if (wr_en1 && in_file(int'(wr_addr1))) begin m_mem[wr_addr1] = wr_data1; m_bsy[wr_addr1] = 0; end
      if (busy_set && in_file(int'(busy_addr))) m_bsy[busy_addr] = 1;
    end
  end

  always @(negedge clk) begin
    chk("byp_rd_a", ifb.rd_data_a, exp_rd(int'(rd_addr_a), 1));
    chk("byp_rd_b", ifb.rd_data_b, exp_rd(int'(rd_addr_b), 1));
    chk("byp_bz_a", {31'b0, ifb.busy_a}, {31'b0, exp_bz(int'(rd_addr_a), 1)});
    chk("byp_bz_b", {31'b0, ifb.busy_b}, {31'b0, exp_bz(int'(rd_addr_b), 1)});
    chk("nob_rd_a", ifn.rd_data_a, exp_rd(int'(rd_addr_a), 0));
    chk("nob_rd_b", ifn.rd_data_b, exp_rd(int'(rd_addr_b), 0));
    chk("nob_bz_a", {31'b0, ifn.busy_a}, {31'b0, exp_bz(int'(rd_addr_a), 0)});
    chk("nob_bz_b", {31'b0, ifn.busy_b}, {31'b0, exp_bz(int'(rd_addr_b), 0)});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wr_en0 = 0; wr_en1 = 0; busy_set = 0;
  endtask

  initial begin
    // Reset held with a write to r5 pending.
    wr_en0 = 1; wr_addr0 = 5; wr_data0 = 32'h1234_5678; rd_addr_a = 5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rd5", ifb.rd_data_a, 32'h0);
      chk("rst_bz5", {31'b0, ifb.busy_a}, 32'h0);
      step();
    end
    idle(); rst = 1;
    @(negedge clk); chk("post_rst_rd5", ifb.rd_data_a, 32'h0);

    // Forwarding vs. non-forwarding on a fresh write.
    step(); wr_en0 = 1; wr_addr0 = 3; wr_data0 = 32'hDEADBEEF; rd_addr_a = 3;
    @(negedge clk);
    chk("byp_same_cyc", ifb.rd_data_a, 32'hDEADBEEF);
    chk("nob_same_cyc", ifn.rd_data_a, 32'h0);
    step(); idle();
    @(negedge clk); chk("nob_next_cyc", ifn.rd_data_a, 32'hDEADBEEF);

    // Port 1 wins on a same-address double write.
    step(); wr_en0 = 1; wr_addr0 = 7; wr_data0 = 32'h11;
    wr_en1 = 1; wr_addr1 = 7; wr_data1 = 32'h22; rd_addr_a = 7;
    @(negedge clk); chk("fwd_prio", ifb.rd_data_a, 32'h22);
    step(); idle();
    @(negedge clk); chk("store_prio", ifn.rd_data_a, 32'h22);

    // Zero register ignores writes and busy marking.
    step(); wr_en0 = 1; wr_addr0 = 0; wr_data0 = '1; busy_set = 1; busy_addr = 0; rd_addr_a = 0;
    @(negedge clk); chk("r0_fwd", ifb.rd_data_a, 32'h0);
    step(); idle();
    @(negedge clk);
    chk("r0_rd", ifb.rd_data_a, 32'h0);
    chk("r0_bz", {31'b0, ifb.busy_a}, 32'h0);

    // Scoreboard set, set-beats-clear, then clear.
    step(); busy_set = 1; busy_addr = 9; rd_addr_b = 9;
    step(); idle();
    @(negedge clk); chk("bz9_set", {31'b0, ifb.busy_b}, 32'h1);
    step(); busy_set = 1; busy_addr = 9; wr_en1 = 1; wr_addr1 = 9; wr_data1 = 32'h5;
    @(negedge clk); chk("bz9_nob_during", {31'b0, ifn.busy_b}, 32'h1);
    step(); idle();
    @(negedge clk); chk("bz9_set_wins", {31'b0, ifb.busy_b}, 32'h1);
    step(); wr_en0 = 1; wr_addr0 = 9; wr_data0 = 32'h6;
    @(negedge clk);
    chk("bz9_byp_clr", {31'b0, ifb.busy_b}, 32'h0);
    chk("bz9_nob_hold", {31'b0, ifn.busy_b}, 32'h1);
    step(); idle();
    @(negedge clk); chk("bz9_nob_clr", {31'b0, ifn.busy_b}, 32'h0);

    // Out-of-range write is dropped, out-of-range read is zero.
    step(); wr_en1 = 1; wr_addr1 = 30; wr_data1 = 32'hABCD; rd_addr_a = 30;
    @(negedge clk); chk("oor_fwd", ifb.rd_data_a, 32'h0);
    step(); idle();
    @(negedge clk); chk("oor_rd", ifn.rd_data_a, 32'h0);

    // Randomised traffic with collisions and occasional reset pulses.
    for (int c = 0; c < 10000; c++) begin
      step();
      if (!rst) rst = 1;
      else if ($urandom_range(0, 199) == 0) rst = 0;
      wr_en0 = 1'($urandom_range(0, 1));
      wr_en1 = 1'($urandom_range(0, 1));
      busy_set = ($urandom_range(0, 9) < 3);
      wr_addr0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wr_addr1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      busy_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr0 : AW'($urandom);
      rd_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr1 : AW'($urandom);
      wr_data0 = $urandom;
      wr_data1 = $urandom;
    end
    step(); idle(); rst = 1;
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
